// File: rtl/fx2_host_emu.sv
// -----------------------------------------------------------------------------
// fx2_host_emu
//
// Stands in for the host PC and the FX2 slave-FIFO endpoints (EP6OUT / EP8IN).
// A comm_fpga-based design can then be driven in simulation or in on-chip
// loopback without a USB link.
//
// A channel command arrives on the request port and goes out to the DUT as
// the comm_fpga byte stream: a header byte {read, chan[6:0]}, a 32-bit
// big-endian length, and then the payload for writes. For reads, the bytes
// the DUT writes to EP8IN are buffered and returned on the rd* stream port.
//
// Ports
//   clk_in, reset_in           single clock; asynchronous active-low reset
//   cmdValid_in / cmdReady_out command handshake (ready only in IDLE)
//   cmdRead_in, cmdChan_in,    command fields: direction, channel, byte count
//   cmdLength_in
//   wrData_in / wrValid_in /   write payload stream into the emulator
//   wrReady_out
//   rdData_out / rdValid_out / read payload stream out of the emulator
//   rdReady_in
//   busy_out                   a command is in progress
//   protoErr_out               sticky: DUT wrote while no room was offered
//   commit_out                 one-cycle pulse per accepted fx2PktEnd_in
//   fx2*                       FX2 slave-FIFO side facing the DUT
// -----------------------------------------------------------------------------
module fx2_host_emu #(
  parameter int IN_DEPTH = 4  // IN buffer capacity in bytes; power of two, 2..16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  // Command request port
  input  logic        cmdValid_in,
  output logic        cmdReady_out,
  input  logic        cmdRead_in,
  input  logic [6:0]  cmdChan_in,
  input  logic [31:0] cmdLength_in,
  // Write payload stream
  input  logic [7:0]  wrData_in,
  input  logic        wrValid_in,
  output logic        wrReady_out,
  // Read payload stream
  output logic [7:0]  rdData_out,
  output logic        rdValid_out,
  input  logic        rdReady_in,
  // Status
  output logic        busy_out,
  output logic        protoErr_out,
  output logic        commit_out,
  // FX2 slave-FIFO interface towards the DUT
  input  logic        fx2FifoSel_in,
  output logic [7:0]  fx2Data_out,
  input  logic [7:0]  fx2Data_in,
  input  logic        fx2Read_in,
  output logic        fx2GotData_out,
  input  logic        fx2Write_in,
  output logic        fx2GotRoom_out,
  input  logic        fx2PktEnd_in
);

  localparam int PTR_W = $clog2(IN_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IN_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,   // waiting for a command
    HDR,    // header byte and four length bytes going out on EP6OUT
    WDATA,  // write payload going out on EP6OUT
    RDATA   // read payload coming back on EP8IN
  } stateType;

  stateType state, stateNext;

  // Low while reset is asserted. It rises on the first edge after release,
  // so cmdReady_out cannot be high during reset even though state is IDLE.
  logic rstDone;

  // OUT holding register: the one byte currently offered to the DUT.
  logic [7:0] outReg;
  logic       outValid;

  logic [2:0]  hdrIdx;     // header bytes already consumed by the DUT
  logic        isRead;     // direction of the current command
  // Holds the full command length through HDR, so the length bytes can be
  // read from it. After that it counts the payload bytes still to move.
  // The channel needs no storage of its own because it goes out in the
  // header byte loaded at acceptance.
  logic [31:0] remaining;

  // IN buffer: a small circular FIFO of bytes written by the DUT.
  logic [7:0]       inMem [IN_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] bufCount;

  logic protoErr;
  logic commit;

  // Handshake qualifiers
  logic outConsume;  // DUT reads the OUT byte on this edge
  logic inCapture;   // DUT writes an IN byte on this edge
  logic inPop;       // host side pops a read byte on this edge
  logic wrAccept;    // a payload byte enters the holding register
  logic badWrite;    // write strobe with no room offered

  assign fx2Data_out    = outReg;
  assign fx2GotData_out = outValid & ~fx2FifoSel_in;
  assign busy_out       = (state != IDLE);
  assign protoErr_out   = protoErr;
  assign commit_out     = commit;
  assign rdValid_out    = (bufCount != '0);
  assign rdData_out     = inMem[rdPtr];

  // A read strobe with nothing offered falls out here and is ignored.
  assign outConsume = ~fx2Read_in & ~fx2FifoSel_in & fx2GotData_out;
  assign inCapture  = ~fx2Write_in & fx2FifoSel_in & fx2GotRoom_out;
  assign inPop      = rdValid_out & rdReady_in;
  assign wrAccept   = wrValid_in & wrReady_out;
  assign badWrite   = ~fx2Write_in & ~fx2GotRoom_out;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples pre-edge values no matter what order the blocks run in.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. Otherwise a path
  // through the case that does not assign it would infer a latch.
  always_comb begin
    stateNext      = state;
    cmdReady_out   = 1'b0;
    wrReady_out    = 1'b0;
    fx2GotRoom_out = 1'b0;

    unique case (state)
      IDLE: begin
        cmdReady_out = rstDone;
        if (cmdValid_in && rstDone) begin
          stateNext = HDR;
        end
      end

      HDR: begin
        // The fifth consumption is the last length byte.
        if (outConsume && (hdrIdx == 3'd4)) begin
          if (remaining == 32'd0) begin
            stateNext = IDLE;
          end else if (isRead) begin
            stateNext = RDATA;
          end else begin
            stateNext = WDATA;
          end
        end
      end

      WDATA: begin
        // Refill in the same cycle the DUT drains the register, so a DUT
        // that reads continuously sees no bubble.
        wrReady_out = (remaining != 32'd0) & (~outValid | outConsume);
        // When remaining is 0 the register holds the final payload byte.
        if (outConsume && (remaining == 32'd0)) begin
          stateNext = IDLE;
        end
      end

      RDATA: begin
        // Room comes from the registered count only. A pop in this cycle
        // does not open space until the next cycle.
        fx2GotRoom_out = fx2FifoSel_in & (bufCount < DEPTH_CNT) & (remaining != 32'd0);
        if ((remaining == 32'd0) && (bufCount == '0)) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: OUT holding register, counters, IN buffer pointers, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rstDone   <= 1'b0;
      outReg    <= 8'h00;
      outValid  <= 1'b0;
      hdrIdx    <= 3'd0;
      isRead    <= 1'b0;
      remaining <= 32'd0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      bufCount  <= '0;
      protoErr  <= 1'b0;
      commit    <= 1'b0;
    end else begin
      rstDone <= 1'b1;
      commit  <= ~fx2PktEnd_in & fx2FifoSel_in;
      if (badWrite) begin
        protoErr <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (cmdValid_in && cmdReady_out) begin
            outReg    <= {cmdRead_in, cmdChan_in};
            outValid  <= 1'b1;
            hdrIdx    <= 3'd0;
            isRead    <= cmdRead_in;
            remaining <= cmdLength_in;
          end
        end

        HDR: begin
          if (outConsume) begin
            hdrIdx <= hdrIdx + 3'd1;
            unique case (hdrIdx)
              3'd0:    outReg <= remaining[31:24];
              3'd1:    outReg <= remaining[23:16];
              3'd2:    outReg <= remaining[15:8];
              3'd3:    outReg <= remaining[7:0];
              default: outValid <= 1'b0;
            endcase
          end
        end

        WDATA: begin
          if (wrAccept) begin
            outReg    <= wrData_in;
            outValid  <= 1'b1;
            remaining <= remaining - 32'd1;
          end else if (outConsume) begin
            outValid <= 1'b0;
          end
        end

        RDATA: begin
          if (inCapture) begin
            remaining <= remaining - 32'd1;
          end
        end

        default: ;
      endcase

      if (inCapture) begin
        wrPtr <= wrPtr + ONE_PTR;
      end
      if (inPop) begin
        rdPtr <= rdPtr + ONE_PTR;
      end
      unique case ({inCapture, inPop})
        2'b10:   bufCount <= bufCount + ONE_CNT;
        2'b01:   bufCount <= bufCount - ONE_CNT;
        default: ;  // idle, or capture and pop together
      endcase
    end
  end

  // NOTE: the buffer storage has no reset. The pointers and the count decide
  // what is valid, so clearing the contents would buy nothing, and it would
  // stop the array from mapping onto distributed RAM.
  always_ff @(posedge clk_in) begin
    if (inCapture) begin
      inMem[wrPtr] <= fx2Data_in;
    end
  end

endmodule

// File: tb/tb_fx2_host_emu.sv
module tb_fx2_host_emu;

  localparam int IN_DEPTH = 4;
  localparam int BUDGET   = 600;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cmdValid_in, cmdReady_out, cmdRead_in;
  logic [6:0]  cmdChan_in;
  logic [31:0] cmdLength_in;
  logic [7:0]  wrData_in;
  logic        wrValid_in, wrReady_out;
  logic [7:0]  rdData_out;
  logic        rdValid_out, rdReady_in;
  logic        busy_out, protoErr_out, commit_out;
  logic        fx2FifoSel_in;
  logic [7:0]  fx2Data_out, fx2Data_in;
  logic        fx2Read_in, fx2GotData_out, fx2Write_in, fx2GotRoom_out, fx2PktEnd_in;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] payBuf [64];

  fx2_host_emu #(.IN_DEPTH(IN_DEPTH)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .cmdValid_in(cmdValid_in), .cmdReady_out(cmdReady_out), .cmdRead_in(cmdRead_in),
    .cmdChan_in(cmdChan_in), .cmdLength_in(cmdLength_in),
    .wrData_in(wrData_in), .wrValid_in(wrValid_in), .wrReady_out(wrReady_out),
    .rdData_out(rdData_out), .rdValid_out(rdValid_out), .rdReady_in(rdReady_in),
    .busy_out(busy_out), .protoErr_out(protoErr_out), .commit_out(commit_out),
    .fx2FifoSel_in(fx2FifoSel_in), .fx2Data_out(fx2Data_out), .fx2Data_in(fx2Data_in),
    .fx2Read_in(fx2Read_in), .fx2GotData_out(fx2GotData_out), .fx2Write_in(fx2Write_in),
    .fx2GotRoom_out(fx2GotRoom_out), .fx2PktEnd_in(fx2PktEnd_in)
  );

  always #5 clk_in = ~clk_in;

  // Each record holds the command, the payload (the host's write data, or
  // the bytes the DUT writes back), a host-side stall count, and the header
  // byte the DUT must see.
  typedef struct {
    logic        rd;
    logic [6:0]  ch;
    int          len;
    logic [47:0] pay;
    int          hold;
    logic [7:0]  expHdr;
  } vecType;

  vecType vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cmdValid_in   = 1'b0;
    cmdRead_in    = 1'b0;
    cmdChan_in    = 7'h00;
    cmdLength_in  = 32'd0;
    wrData_in     = 8'h00;
    wrValid_in    = 1'b0;
    rdReady_in    = 1'b0;
    fx2FifoSel_in = 1'b0;
    fx2Data_in    = 8'h00;
    fx2Read_in    = 1'b1;
    fx2Write_in   = 1'b1;
    fx2PktEnd_in  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue_cmd(input logic rd, input logic [6:0] ch, input logic [31:0] len);
    check("cmd_ready", cmdReady_out, 1);
    if (!cmdReady_out) do_reset();
    cmdValid_in  = 1'b1;
    cmdRead_in   = rd;
    cmdChan_in   = ch;
    cmdLength_in = len;
    @(posedge clk_in);
    #1 cmdValid_in = 1'b0;
    check("cmd_busy", busy_out, 1);
    check("cmd_ready_low", cmdReady_out, 0);
  endtask

  // Host writes len bytes from payBuf. The DUT side reads EP6OUT with
  // probability pct per cycle. If abortAt > 0, the task returns as soon as
  // that many bytes have been read and leaves the command in flight.
  task automatic run_write(input logic [6:0] ch, input int len, input int pct,
                           input int abortAt, output logic [7:0] hdr);
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    int pi, cyc;
    bit done, consumed, rdStrobe;
    pi = 0; cyc = 0; done = 1'b0; hdr = 8'h00;
    expQ.push_back({1'b0, ch});
    for (int k = 3; k >= 0; k--) expQ.push_back(8'(len >> (8 * k)));
    for (int k = 0; k < len && k < 64; k++) expQ.push_back(payBuf[k]);
    issue_cmd(1'b0, ch, 32'(len));
    while (!done) begin
      fx2FifoSel_in = 1'b0;
      wrValid_in    = (int'($urandom_range(99)) < pct);
      wrData_in     = (pi < 64) ? payBuf[pi] : 8'h00;
      rdStrobe      = (int'($urandom_range(99)) < pct);
      fx2Read_in    = ~rdStrobe;
      #1;
      consumed = rdStrobe && fx2GotData_out;
      if (consumed) gotQ.push_back(fx2Data_out);
      if (wrValid_in && wrReady_out) pi++;
      @(posedge clk_in);
      #1 cyc++;
      if (abortAt > 0 && gotQ.size() == abortAt) return;
      if (consumed && gotQ.size() == expQ.size()) begin
        check("wr_busy_fall", busy_out, 0);
        done = 1'b1;
      end else if (!busy_out) begin
        check("wr_early_idle", gotQ.size(), expQ.size());
        done = 1'b1;
      end else if (cyc >= BUDGET) begin
        check("wr_timeout", busy_out, 0);
        done = 1'b1;
      end
    end
    idle_inputs();
    check("wr_nbytes", gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) check("wr_byte", gotQ[i], expQ[i]);
    check("wr_accepts", pi, len);
    if (gotQ.size() > 0) hdr = gotQ[0];
    if (busy_out) do_reset();
  endtask

  // Host reads len bytes. The DUT side writes payBuf bytes to EP8IN with
  // probability wrPct whenever room is offered. The host pops with
  // probability rdyPct, and not at all during the first hold cycles.
  task automatic run_read(input logic [6:0] ch, input int len, input int wrPct,
                          input int rdyPct, input int hold, output logic [7:0] hdr);
    logic [7:0] expH[$];
    logic [7:0] gotH[$];
    logic [7:0] modelQ[$];
    logic [7:0] tmp;
    int captures, popped, modelRem, cyc;
    bit done, hdrPhase, wantW, doW, doPop;
    captures = 0; popped = 0; modelRem = len; cyc = 0; done = 1'b0; hdr = 8'h00;
    expH.push_back({1'b1, ch});
    for (int k = 3; k >= 0; k--) expH.push_back(8'(len >> (8 * k)));
    issue_cmd(1'b1, ch, 32'(len));
    while (!done) begin
      if (hold > 0 && cyc == hold)
        check("bp_captures", captures, (len < IN_DEPTH) ? len : IN_DEPTH);
      hdrPhase      = (gotH.size() < 5);
      fx2FifoSel_in = ~hdrPhase;
      fx2Read_in    = ~hdrPhase;
      wantW         = !hdrPhase && (int'($urandom_range(99)) < wrPct);
      rdReady_in    = (cyc >= hold) && (int'($urandom_range(99)) < rdyPct);
      fx2Data_in    = (captures < 64) ? payBuf[captures] : 8'h00;
      fx2Write_in   = 1'b1;
      #1;
      if (hdrPhase && fx2GotData_out) gotH.push_back(fx2Data_out);
      if (!hdrPhase) begin
        check("rd_room", fx2GotRoom_out, (modelQ.size() < IN_DEPTH) && (modelRem > 0));
        check("rd_valid", rdValid_out, modelQ.size() > 0);
        if (modelQ.size() > 0) check("rd_data", rdData_out, modelQ[0]);
      end
      doW         = wantW && fx2GotRoom_out;
      fx2Write_in = ~doW;
      doPop       = rdValid_out && rdReady_in;
      @(posedge clk_in);
      #1 cyc++;
      if (doPop && modelQ.size() > 0) begin
        tmp = modelQ.pop_front();
        popped++;
      end
      if (doW) begin
        modelQ.push_back(payBuf[captures]);
        captures++;
        modelRem--;
      end
      if (!busy_out) begin
        done = 1'b1;
      end else if (cyc >= BUDGET) begin
        check("rd_timeout", busy_out, 0);
        done = 1'b1;
      end
    end
    idle_inputs();
    check("rd_hdr_nbytes", gotH.size(), 5);
    for (int i = 0; i < gotH.size() && i < 5; i++) check("rd_hdr_byte", gotH[i], expH[i]);
    check("rd_popped", popped, len);
    check("rd_proto", protoErr_out, 0);
    check("rd_valid_end", rdValid_out, 0);
    if (gotH.size() > 0) hdr = gotH[0];
    if (busy_out) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr;
    logic [7:0] hq[$];
    int cyc;

    vecs[0] = '{rd: 1'b0, ch: 7'h05, len: 3, pay: 48'hA1B2C3000000, hold: 0,  expHdr: 8'h05};
    vecs[1] = '{rd: 1'b1, ch: 7'h02, len: 2, pay: 48'h7E7F00000000, hold: 0,  expHdr: 8'h82};
    vecs[2] = '{rd: 1'b1, ch: 7'h11, len: 6, pay: 48'h101112131415, hold: 14, expHdr: 8'h91};
    vecs[3] = '{rd: 1'b0, ch: 7'h7F, len: 0, pay: 48'h0,            hold: 0,  expHdr: 8'h7F};
    vecs[4] = '{rd: 1'b1, ch: 7'h40, len: 0, pay: 48'h0,            hold: 0,  expHdr: 8'hC0};
    vecs[5] = '{rd: 1'b0, ch: 7'h2A, len: 6, pay: 48'h00FF55AA0180, hold: 0,  expHdr: 8'h2A};

    // Reset state
    idle_inputs();
    reset_in      = 1'b0;
    fx2FifoSel_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_cmd_ready", cmdReady_out, 0);
    check("rst_wr_ready", wrReady_out, 0);
    check("rst_rd_valid", rdValid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_proto", protoErr_out, 0);
    check("rst_commit", commit_out, 0);
    check("rst_got_room", fx2GotRoom_out, 0);
    fx2FifoSel_in = 1'b0;
    #1;
    check("rst_got_data", fx2GotData_out, 0);
    check("rst_fx2_data", fx2Data_out, 8'h00);
    reset_in = 1'b1;
    #1 check("rel_cmd_ready_pre", cmdReady_out, 0);
    @(posedge clk_in);
    #1 check("rel_cmd_ready_post", cmdReady_out, 1);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 6; k++) payBuf[k] = vecs[v].pay[47 - 8 * k -: 8];
      if (vecs[v].rd) run_read(vecs[v].ch, vecs[v].len, 100, 100, vecs[v].hold, hdr);
      else            run_write(vecs[v].ch, vecs[v].len, 100, 0, hdr);
      check("tbl_hdr", hdr, vecs[v].expHdr);
    end

    // Large length: big-endian length bytes, then payload requested
    idle_inputs();
    issue_cmd(1'b0, 7'h0F, 32'hDEADBEEF);
    cyc = 0;
    while (hq.size() < 5 && cyc < 40) begin
      fx2Read_in = 1'b0;
      #1;
      if (fx2GotData_out) hq.push_back(fx2Data_out);
      @(posedge clk_in);
      #1 cyc++;
    end
    check("big_nbytes", hq.size(), 5);
    if (hq.size() == 5) begin
      check("big_b0", hq[0], 8'h0F);
      check("big_b1", hq[1], 8'hDE);
      check("big_b2", hq[2], 8'hAD);
      check("big_b3", hq[3], 8'hBE);
      check("big_b4", hq[4], 8'hEF);
    end
    fx2Read_in = 1'b1;
    #1 check("big_wr_ready", wrReady_out, 1);
    do_reset();

    // Reset in WDATA after 2 of 4 payload bytes
    for (int k = 0; k < 4; k++) payBuf[k] = 8'(8'hC0 + k);
    run_write(7'h33, 4, 100, 7, hdr);
    check("pre_rst_got_data", fx2GotData_out, 1);
    check("pre_rst_busy", busy_out, 1);
    idle_inputs();
    #2 reset_in = 1'b0;
    #1;
    check("mid_rst_got_data", fx2GotData_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_cmd_ready", cmdReady_out, 0);
    @(posedge clk_in);
    #1 reset_in = 1'b1;
    #1 check("mid_rel_cmd_ready_pre", cmdReady_out, 0);
    @(posedge clk_in);
    #1 check("mid_rel_cmd_ready_post", cmdReady_out, 1);
    payBuf[0] = 8'h5A;
    run_write(7'h01, 1, 100, 0, hdr);
    check("post_rst_hdr", hdr, 8'h01);

    // Randomized transactions
    for (int t = 0; t < 18; t++) begin
      logic       rd;
      logic [6:0] ch;
      int         len;
      rd  = 1'($urandom_range(1));
      ch  = 7'($urandom);
      len = int'($urandom_range(12));
      for (int k = 0; k < 64; k++) payBuf[k] = 8'($urandom);
      if (rd) run_read(ch, len, 40 + int'($urandom_range(60)), 30 + int'($urandom_range(70)), 0, hdr);
      else    run_write(ch, len, 50 + int'($urandom_range(50)), 0, hdr);
      check("rand_hdr", hdr, {rd, ch});
    end

    // Stray write strobe in IDLE sets the sticky error
    idle_inputs();
    fx2Write_in = 1'b0;
    #1 check("stray_pre", protoErr_out, 0);
    @(posedge clk_in);
    #1 fx2Write_in = 1'b1;
    check("stray_set", protoErr_out, 1);
    payBuf[0] = 8'h11;
    payBuf[1] = 8'h22;
    run_write(7'h09, 2, 100, 0, hdr);
    check("stray_sticky", protoErr_out, 1);

    // Packet commit
    fx2FifoSel_in = 1'b1;
    fx2PktEnd_in  = 1'b0;
    #1 check("commit_pre", commit_out, 0);
    @(posedge clk_in);
    #1 fx2PktEnd_in = 1'b1;
    check("commit_pulse", commit_out, 1);
    @(posedge clk_in);
    #1 check("commit_single", commit_out, 0);
    fx2FifoSel_in = 1'b0;
    fx2PktEnd_in  = 1'b0;
    @(posedge clk_in);
    #1 fx2PktEnd_in = 1'b1;
    check("commit_sel0", commit_out, 0);
    check("commit_no_busy", busy_out, 0);

    do_reset();
    check("proto_cleared", protoErr_out, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fx2_host_emu.md
Name: fx2_host_emu

Overview:
- Emulates the host PC plus the FX2 slave-FIFO endpoints (EP6OUT/EP8IN), so a comm_fpga-based design can be exercised in simulation or on-chip loopback without USB.
- Takes channel read/write commands on a request port and serialises them into the comm_fpga byte protocol: header byte, 32-bit big-endian length, then payload.
- Answers comm_fpga's fx2Read/fx2Write strobes and returns read data on a stream port.

Parameters:
IN_DEPTH, 4, capacity in bytes of the internal IN (FPGA-to-host) buffer; power of two, 2..16.

Ports:
clk_in  input  1  single clock; all state changes on the rising edge.
reset_in  input  1  asynchronous, active-low reset.
cmdValid_in  input  1  command request present.
cmdReady_out  output  1  high only in IDLE; the command is accepted on an edge where cmdValid_in and cmdReady_out are both high.
cmdRead_in  input  1  1 = channel read, 0 = channel write.
cmdChan_in  input  7  channel address.
cmdLength_in  input  32  byte count.
wrData_in  input  8  write payload byte.
wrValid_in  input  1  write payload byte present.
wrReady_out  output  1  payload byte is taken on an edge where wrValid_in and wrReady_out are both high.
rdData_out  output  8  read payload byte.
rdValid_out  output  1  read payload byte present.
rdReady_in  input  1  a read byte is popped on an edge where rdValid_out and rdReady_in are both high.
busy_out  output  1  high whenever state is not IDLE.
protoErr_out  output  1  sticky protocol-violation flag.
commit_out  output  1  one-cycle pulse on each accepted fx2PktEnd_in.
fx2FifoSel_in  input  1  from DUT; 0 = EP6OUT, 1 = EP8IN.
fx2Data_out  output  8  byte presented to the DUT.
fx2Data_in  input  8  byte written by the DUT.
fx2Read_in  input  1  active-low read strobe.
fx2GotData_out  output  1  OUT byte available.
fx2Write_in  input  1  active-low write strobe.
fx2GotRoom_out  output  1  IN space available.
fx2PktEnd_in  input  1  active-low packet commit.

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - state=IDLE; cmdReady_out=0 while reset is asserted, 1 from the first edge after release;
  - wrReady_out, rdValid_out, busy_out, protoErr_out, commit_out, fx2GotData_out, fx2GotRoom_out all 0;
  - fx2Data_out=8'h00; IN buffer emptied; all counters 0.
- Reset asserted mid-command abandons the command. Bytes already consumed by the DUT are not replayed.
- Command acceptance:
  - Latch read flag, channel and length; go to HDR.
  - OUT holding register is loaded with {cmdRead_in, cmdChan_in}; hdrIdx=0.
- OUT holding register (one byte plus a valid bit):
  - fx2Data_out = register contents.
  - fx2GotData_out = valid & ~fx2FifoSel_in.
  - An OUT byte is consumed on an edge where fx2Read_in=0, fx2FifoSel_in=0 and fx2GotData_out=1.
  - A read strobe while fx2GotData_out=0 is ignored; no error is raised.
- HDR state:
  - Each consumption loads the next length byte: [31:24], [23:16], [15:8], [7:0].
  - After the 5th byte is consumed:
    - write with length>0 -> WDATA;
    - read with length>0 -> RDATA;
    - length=0 -> IDLE.
- WDATA state:
  - wrReady_out = ~valid, or the holding register is being consumed in the same cycle (zero-bubble refill).
  - Each accepted payload byte loads the holding register and decrements a 32-bit remaining counter.
  - wrReady_out=0 once remaining reaches 0.
  - Go to IDLE on the edge where the final payload byte is consumed by the DUT.
- RDATA state:
  - fx2GotRoom_out = fx2FifoSel_in & (bufCount<IN_DEPTH) & (remaining>0). This is combinational from registered counts; a same-cycle pop does not free space.
  - An IN byte is captured on an edge where fx2Write_in=0, fx2FifoSel_in=1 and fx2GotRoom_out=1; remaining decrements.
  - Go to IDLE when remaining=0 and the buffer is empty.
- Write strobe whenever fx2GotRoom_out=0 (any state): byte dropped, protoErr_out set to 1.
- Simultaneous capture and pop in the same cycle: bufCount unchanged.
- rdData_out shows the buffer head.
- fx2PktEnd_in=0 with fx2FifoSel_in=1 produces a commit_out pulse on the next cycle; it has no other effect.
- Arithmetic: remaining wraps nowhere. No decrement occurs at 0, and lengths up to 2^32-1 are legal.

Test Plan:
- Write: chan 0x05, length 3, payload A1 B2 C3, DUT reads continuously -> DUT sees 05 00 00 00 03 A1 B2 C3 on consecutive reads; busy_out falls after the 8th byte.
- Read: chan 0x02, length 2, DUT writes 7E 7F -> header byte 82, rdData_out gives 7E then 7F; then IDLE.
- Backpressure: read of length 6 with IN_DEPTH=4 and rdReady_in=0 -> fx2GotRoom_out drops after 4 captures; raising rdReady_in resumes and all 6 bytes arrive in order.
- Zero-length write to chan 0x7F -> 5 bytes 7F 00 00 00 00, no payload requested, IDLE.
- Stray write strobe in IDLE -> protoErr_out=1 and stays set until reset; fx2PktEnd_in=0 with fx2FifoSel_in=1 -> single commit_out pulse.
- Reset_in pulsed low in WDATA after 2 of 4 bytes -> fx2GotData_out=0 immediately; cmdReady_out=1 one edge after release.
